// File: rtl/exception_context_unit_if.sv
// Memory bus between the exception context unit and the stack memory.
// master: the context unit (issues req/we/addr/wdata, receives rdata/ack).
// slave:  the memory (returns rdata/ack). mem_ack completes the current access.
interface exception_context_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/exception_context_unit.sv
// Exception context unit: on an enabled interrupt it pushes PC and PSW onto the
// stack, then loads the handler vector, the new SP and the PSW with interrupts
// masked. On reti it pops PSW and PC and restores PC, SP and PSW.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   irq_req           level interrupt request (honoured only when psw_in[IE_BIT])
//   irq_vector        handler entry address, driven onto pc_out at entry
//   reti              return-from-interrupt request (sampled in idle only)
//   pc_in/sp_in/psw_in current CPU context, latched when a sequence starts
//   mem               stack memory bus (master side)
//   pc_wr/pc_out, sp_wr/sp_out          register write-back strobes and data
//   psw_wr_en/psw_wr_data               PSW byte enables and data
//   irq_ack           one-cycle pulse when entry completes
//   busy              high whenever a sequence is in progress
module exception_context_unit #(
    parameter int unsigned IE_BIT     = 4,
    parameter int unsigned WORD_BYTES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            irq_req,
    input  logic [15:0]                     irq_vector,
    input  logic                            reti,
    input  logic [15:0]                     pc_in,
    input  logic [15:0]                     sp_in,
    input  logic [15:0]                     psw_in,
    exception_context_unit_if.master        mem,
    output logic                            pc_wr,
    output logic [15:0]                     pc_out,
    output logic                            sp_wr,
    output logic [15:0]                     sp_out,
    output logic [1:0]                      psw_wr_en,
    output logic [15:0]                     psw_wr_data,
    output logic                            irq_ack,
    output logic                            busy
);

    localparam logic [15:0] Step1  = 16'(WORD_BYTES);
    localparam logic [15:0] Step2  = 16'(2 * WORD_BYTES);
    localparam logic [15:0] IeMask = 16'(1) << IE_BIT;

    typedef enum logic [2:0] {
        StIdle,
        StPushPc,
        StPushPsw,
        StLoadVec,
        StPopPsw,
        StPopPc,
        StRestore
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] sp_q, sp_d;
    logic [15:0] psw_q, psw_d;
    logic [15:0] pop_pc_q, pop_pc_d;
    logic [15:0] pop_psw_q, pop_psw_d;

    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= 16'h0000;
            sp_q      <= 16'h0000;
            psw_q     <= 16'h0000;
            pop_pc_q  <= 16'h0000;
            pop_psw_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            psw_q     <= psw_d;
            pop_pc_q  <= pop_pc_d;
            pop_psw_q <= pop_psw_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        sp_d        = sp_q;
        psw_d       = psw_q;
        pop_pc_d    = pop_pc_q;
        pop_psw_d   = pop_psw_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 16'h0000;
        mem_wdata   = 16'h0000;
        pc_wr       = 1'b0;
        pc_out      = 16'h0000;
        sp_wr       = 1'b0;
        sp_out      = 16'h0000;
        psw_wr_en   = 2'b00;
        psw_wr_data = 16'h0000;
        irq_ack     = 1'b0;
        busy        = (state_q != StIdle);

        case (state_q)
            StIdle: begin
                // reti has priority over a pending interrupt
                if (reti) begin
                    state_d = StPopPsw;
                end else if (irq_req && psw_in[IE_BIT]) begin
                    state_d = StPushPc;
                end
                if (state_d != StIdle) begin
                    pc_d  = pc_in;
                    sp_d  = sp_in;
                    psw_d = psw_in;
                end
            end
            StPushPc: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_q - Step1;
                mem_wdata = pc_q;
                if (mem.mem_ack) state_d = StPushPsw;
            end
            StPushPsw: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_q - Step2;
                mem_wdata = psw_q;
                if (mem.mem_ack) state_d = StLoadVec;
            end
            StLoadVec: begin
                pc_wr       = 1'b1;
                pc_out      = irq_vector;
                sp_wr       = 1'b1;
                sp_out      = sp_q - Step2;
                psw_wr_en   = 2'b11;
                psw_wr_data = psw_q & ~IeMask;
                irq_ack     = 1'b1;
                state_d     = StIdle;
            end
            StPopPsw: begin
                mem_req  = 1'b1;
                mem_addr = sp_q;
                if (mem.mem_ack) begin
                    pop_psw_d = mem.mem_rdata;
                    state_d   = StPopPc;
                end
            end
            StPopPc: begin
                mem_req  = 1'b1;
                mem_addr = sp_q + Step1;
                if (mem.mem_ack) begin
                    pop_pc_d = mem.mem_rdata;
                    state_d  = StRestore;
                end
            end
            StRestore: begin
                pc_wr       = 1'b1;
                pc_out      = pop_pc_q;
                sp_wr       = 1'b1;
                sp_out      = sp_q + Step2;
                psw_wr_en   = 2'b11;
                psw_wr_data = pop_psw_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Reset silences every output at once so an aborted sequence never
        // leaks a strobe or a bus request in the reset cycle itself.
        if (rst) begin
            mem_req     = 1'b0;
            mem_we      = 1'b0;
            mem_addr    = 16'h0000;
            mem_wdata   = 16'h0000;
            pc_wr       = 1'b0;
            pc_out      = 16'h0000;
            sp_wr       = 1'b0;
            sp_out      = 16'h0000;
            psw_wr_en   = 2'b00;
            psw_wr_data = 16'h0000;
            irq_ack     = 1'b0;
            busy        = 1'b0;
        end
    end

    assign mem.mem_req   = mem_req;
    assign mem.mem_we    = mem_we;
    assign mem.mem_addr  = mem_addr;
    assign mem.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_exception_context_unit.sv
// Randomized bench for exception_context_unit. A behavioural stack model
// predicts the bus traffic and write-back of each entry/return sequence.
module tb_exception_context_unit;
    localparam int unsigned IeBit     = 4;
    localparam int unsigned WordBytes = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq_req, reti;
    logic [15:0] irq_vector, pc_in, sp_in, psw_in;
    logic        pc_wr, sp_wr, irq_ack, busy;
    logic [15:0] pc_out, sp_out, psw_wr_data;
    logic [1:0]  psw_wr_en;

    exception_context_unit_if bus ();

    exception_context_unit #(
        .IE_BIT     (IeBit),
        .WORD_BYTES (WordBytes)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_req     (irq_req),
        .irq_vector  (irq_vector),
        .reti        (reti),
        .pc_in       (pc_in),
        .sp_in       (sp_in),
        .psw_in      (psw_in),
        .mem         (bus),
        .pc_wr       (pc_wr),
        .pc_out      (pc_out),
        .sp_wr       (sp_wr),
        .sp_out      (sp_out),
        .psw_wr_en   (psw_wr_en),
        .psw_wr_data (psw_wr_data),
        .irq_ack     (irq_ack),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } acc_t;

    typedef struct {
        int unsigned cyc;
        logic        pc_wr;
        logic [15:0] pc_out;
        logic        sp_wr;
        logic [15:0] sp_out;
        logic [1:0]  psw_en;
        logic [15:0] psw_data;
        logic        irq_ack;
    } stb_t;

    acc_t        acc_q[$];
    stb_t        stb_q[$];
    logic [15:0] mem[logic [15:0]];

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: ack after ack_delay wait cycles, random ack noise when idle.
    int unsigned ack_delay = 0;
    int unsigned wcnt      = 0;
    bit          active    = 1'b0;
    acc_t        cur;

    always @(negedge clk) begin
        if (rst) begin
            bus.mem_ack = 1'b0;
            active      = 1'b0;
        end else if (bus.mem_req) begin
            if (!active) begin
                active    = 1'b1;
                wcnt      = 0;
                cur.we    = bus.mem_we;
                cur.addr  = bus.mem_addr;
                cur.wdata = bus.mem_wdata;
            end else begin
                check_eq("hold_addr", bus.mem_addr, cur.addr);
                check_eq("hold_we", bus.mem_we, cur.we);
                if (cur.we) check_eq("hold_wdata", bus.mem_wdata, cur.wdata);
            end
            if (wcnt >= ack_delay) begin
                bus.mem_ack = 1'b1;
                active      = 1'b0;
                acc_q.push_back(cur);
                if (cur.we) mem[cur.addr] = cur.wdata;
                else bus.mem_rdata = mem.exists(cur.addr) ? mem[cur.addr] : 16'h0000;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 16'($urandom);
                wcnt++;
            end
        end else begin
            active        = 1'b0;
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = 16'($urandom);
        end
    end

    always @(negedge clk) begin
        if (pc_wr || sp_wr || (psw_wr_en != 2'b00) || irq_ack)
            stb_q.push_back('{cyc, pc_wr, pc_out, sp_wr, sp_out, psw_wr_en, psw_wr_data, irq_ack});
    end

    task automatic wait_strobe(output bit ok);
        int n = 0;
        while (stb_q.size() == 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = (stb_q.size() != 0);
        check_eq("strobe_seen", ok, 1);
    endtask

    task automatic do_entry(input logic [15:0] pc, input logic [15:0] sp, input logic [15:0] psw,
                            input logic [15:0] vec, input int unsigned dly);
        logic [15:0] exp_psw;
        int unsigned t0;
        bit          ok;
        acc_q.delete();
        stb_q.delete();
        ack_delay = dly;
        @(posedge clk); #2;
        pc_in = pc; sp_in = sp; psw_in = psw; irq_vector = vec; irq_req = 1'b1; reti = 1'b0;
        t0 = cyc;
        @(posedge clk); #2;
        // Context changes mid-sequence must not matter; IE cleared so the held
        // request is not taken again on return to idle.
        pc_in  = 16'($urandom);
        sp_in  = 16'($urandom);
        psw_in = 16'($urandom);
        psw_in[IeBit] = 1'b0;
        wait_strobe(ok);
        if (ok) begin
            exp_psw = psw;
            exp_psw[IeBit] = 1'b0;
            check_eq("entry_acc_cnt", acc_q.size(), 2);
            if (acc_q.size() >= 2) begin
                check_eq("push_pc_we", acc_q[0].we, 1);
                check_eq("push_pc_addr", acc_q[0].addr, 16'(sp - WordBytes));
                check_eq("push_pc_data", acc_q[0].wdata, pc);
                check_eq("push_psw_we", acc_q[1].we, 1);
                check_eq("push_psw_addr", acc_q[1].addr, 16'(sp - 2 * WordBytes));
                check_eq("push_psw_data", acc_q[1].wdata, psw);
            end
            check_eq("entry_pc_wr", stb_q[0].pc_wr, 1);
            check_eq("entry_pc_out", stb_q[0].pc_out, vec);
            check_eq("entry_sp_wr", stb_q[0].sp_wr, 1);
            check_eq("entry_sp_out", stb_q[0].sp_out, 16'(sp - 2 * WordBytes));
            check_eq("entry_psw_en", stb_q[0].psw_en, 2'b11);
            check_eq("entry_psw_data", stb_q[0].psw_data, exp_psw);
            check_eq("entry_irq_ack", stb_q[0].irq_ack, 1);
            if (dly == 0) check_eq("entry_latency", stb_q[0].cyc - t0, 3);
        end
        @(negedge clk);
        check_eq("entry_idle_after", busy, 0);
        repeat (2) @(negedge clk);
        check_eq("entry_single_pulse", stb_q.size(), 1);
        check_eq("entry_no_reentry", acc_q.size(), 2);
        irq_req = 1'b0;
    endtask

    task automatic do_return(input logic [15:0] sp, input logic [15:0] exp_pc,
                             input logic [15:0] exp_psw, input int unsigned dly, input bit with_irq);
        int unsigned t0;
        bit          ok;
        acc_q.delete();
        stb_q.delete();
        ack_delay = dly;
        @(posedge clk); #2;
        sp_in  = sp;
        pc_in  = 16'($urandom);
        psw_in = 16'($urandom);
        if (with_irq) psw_in[IeBit] = 1'b1;
        irq_req = with_irq;
        reti    = 1'b1;
        t0 = cyc;
        @(posedge clk); #2;
        reti = 1'b0; irq_req = 1'b0; sp_in = 16'($urandom);
        wait_strobe(ok);
        if (ok) begin
            check_eq("ret_acc_cnt", acc_q.size(), 2);
            if (acc_q.size() >= 2) begin
                check_eq("pop_psw_we", acc_q[0].we, 0);
                check_eq("pop_psw_addr", acc_q[0].addr, sp);
                check_eq("pop_pc_we", acc_q[1].we, 0);
                check_eq("pop_pc_addr", acc_q[1].addr, 16'(sp + WordBytes));
            end
            check_eq("ret_pc_wr", stb_q[0].pc_wr, 1);
            check_eq("ret_pc_out", stb_q[0].pc_out, exp_pc);
            check_eq("ret_sp_wr", stb_q[0].sp_wr, 1);
            check_eq("ret_sp_out", stb_q[0].sp_out, 16'(sp + 2 * WordBytes));
            check_eq("ret_psw_en", stb_q[0].psw_en, 2'b11);
            check_eq("ret_psw_data", stb_q[0].psw_data, exp_psw);
            check_eq("ret_irq_ack", stb_q[0].irq_ack, 0);
            if (dly == 0) check_eq("ret_latency", stb_q[0].cyc - t0, 3);
        end
        @(negedge clk);
        check_eq("ret_idle_after", busy, 0);
    endtask

    initial begin
        logic [15:0] pc, sp, psw, vec;
        int unsigned dly;
        bit          seen_busy;
        int          n;

        rst = 1'b1; irq_req = 1'b0; reti = 1'b0;
        irq_vector = 16'h0000; pc_in = 16'h0000; sp_in = 16'h0000; psw_in = 16'h0000;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mem_req", bus.mem_req, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 0);
        check_eq("rst_pc_out", pc_out, 0);
        check_eq("rst_sp_out", sp_out, 0);
        check_eq("rst_psw_data", psw_wr_data, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_strobes", {pc_wr, sp_wr, psw_wr_en, irq_ack}, 0);

        // Zero-wait entry and matching return
        do_entry(16'h1234, 16'h0800, 16'h0013, 16'h0040, 0);
        do_return(16'h07FC, 16'h1234, 16'h0013, 0, 1'b0);

        // Masked request
        acc_q.delete();
        stb_q.delete();
        seen_busy = 1'b0;
        @(posedge clk); #2;
        psw_in = 16'h0003; irq_req = 1'b1;
        repeat (4) begin
            @(negedge clk);
            seen_busy |= busy;
        end
        check_eq("masked_busy", seen_busy, 0);
        check_eq("masked_no_access", acc_q.size(), 0);
        irq_req = 1'b0;

        // reti wins over a simultaneous enabled interrupt
        mem[16'h2000] = 16'h5555;
        mem[16'h2002] = 16'h6666;
        do_return(16'h2000, 16'h6666, 16'h5555, 1, 1'b1);

        // Wait states with stack pointer wrap, both directions
        do_entry(16'hAAAA, 16'h0002, 16'h0010, 16'h0100, 3);
        do_return(16'hFFFE, 16'hAAAA, 16'h0010, 3, 1'b0);

        // Reset while waiting for the PSW push
        acc_q.delete();
        stb_q.delete();
        ack_delay = 5;
        @(posedge clk); #2;
        pc_in = 16'h4321; sp_in = 16'h0400; psw_in = 16'h0010; irq_req = 1'b1;
        @(posedge clk); #2;
        irq_req = 1'b0;
        n = 0;
        while (acc_q.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_mid_first_push", acc_q.size(), 1);
        @(posedge clk); #2;
        check_eq("rst_mid_in_push_psw", bus.mem_addr, 16'h03FC);
        rst = 1'b1;
        @(posedge clk); #2;
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_mem_req", bus.mem_req, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst_mid_no_strobe", stb_q.size(), 0);
        check_eq("rst_mid_idle", busy, 0);

        // Random entry/return pairs through the stack model
        for (int i = 0; i < 25; i++) begin
            pc  = 16'($urandom);
            sp  = 16'($urandom);
            psw = 16'($urandom);
            psw[IeBit] = 1'b1;
            vec = 16'($urandom);
            dly = $urandom_range(0, 3);
            do_entry(pc, sp, psw, vec, dly);
            dly = $urandom_range(0, 3);
            do_return(16'(sp - 2 * WordBytes), pc, psw, dly, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
